sort_loader: RTL and testbench
==============================

# sort_loader

Input stage of the sort datapath. Accepts a serial stream of DATA_N words over a valid/ready handshake and assembles them into the parallel array the bubble sorter reads. Issues a one-cycle start_sort pulse, then holds the array stable and blocks input until the sorter has emitted DATA_N valid outputs. Sits directly upstream of bubble_sort and drives its data_in/start_sort; it also observes the sorter's out_vld.

## Interface
- DATA_W, 4, width of one data word
- DATA_N, 4, words per sort batch (≥2)
- CNT_W, 8, width of the completed-batch counter
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_vld  in  1  upstream word valid
- in_data  in  DATA_W  upstream word
- in_rdy  out  1  loader can accept a word this cycle
- data_arr  out  DATA_N x DATA_W (unpacked [DATA_N-1:0])  batch to sorter; index = arrival order
- start_sort  out  1  one-cycle pulse: batch ready, sorter may start
- sort_out_vld  in  1  sorter out_vld, one pulse per emitted word
- busy  out  1  batch handed off, sorter not yet finished
- batch_cnt  out  CNT_W  completed batches, wraps 2^CNT_W-1 → 0
- err_stray  out  1  sticky: sort_out_vld seen outside WAIT

## Operation
- States: FILL, START, WAIT. Reset state FILL.
- Counters: wr_idx and rd_cnt, width max(1,$clog2(DATA_N)).
- FILL: in_rdy=1. A word is accepted on a rising edge with in_vld&&in_rdy: data_arr[wr_idx] ← in_data, wr_idx+1. If accepted with wr_idx==DATA_N-1: wr_idx←0, go START. in_vld=0 → nothing changes.
- START (exactly one cycle): start_sort=1, in_rdy=0, busy=1. Go WAIT unconditionally.
- WAIT: in_rdy=0, busy=1. Each cycle with sort_out_vld=1 increments rd_cnt. The DATA_N-th pulse: rd_cnt←0, batch_cnt+1 (wraps), go FILL.
- sort_out_vld in FILL or START: ignored for counting; err_stray←1. Cleared only by reset.
- data_arr is written only in FILL; constant from the START cycle until return to FILL. Unwritten entries keep old values.
- in_data is ignored whenever in_rdy=0, regardless of in_vld.
- in_rdy, start_sort and busy are decoded from the state register only, never from inputs. No combinational in→out paths.
- Reset (rst_n low, any time, including mid-batch or in WAIT): state FILL, wr_idx=rd_cnt=0, data_arr all 0, batch_cnt=0, err_stray=0. Partial batch discarded. Outputs take their reset values immediately and asynchronously.

## Timing
- Reset values: in_rdy=1 (FILL), start_sort=0, busy=0, data_arr=0, batch_cnt=0, err_stray=0.
- Back-to-back acceptance, 1 word/cycle in FILL.
- Last word accepted at edge k → start_sort=1, in_rdy=0 during cycle k..k+1. busy=1 from edge k.
- DATA_N-th sort_out_vld sampled at edge m → in_rdy=1, busy=0 and batch_cnt updated from edge m. A new word can be accepted at edge m+1.
- Minimum batch period: DATA_N (fill) + 1 (start) + sorter latency.
- A sort_out_vld pulse in the START cycle sets err_stray and is not counted.

## Test plan
- Reset then idle: rst_n low 3 cycles, release → in_rdy=1, start_sort=0, busy=0, batch_cnt=0, data_arr={0,0,0,0}.
- Fill with gaps: send 3,9,1,12 with in_vld low between words → data_arr[0..3]=3,9,1,12. Single start_sort pulse one cycle after the 12 is accepted. in_rdy=0 from then on.
- Blocking: in WAIT, hold in_vld=1, in_data=7 for 10 cycles → data_arr unchanged, no further start_sort.
- Completion: 4 sort_out_vld pulses (non-consecutive) → after 4th, batch_cnt=1, in_rdy=1, busy=0. A 5th stray pulse in FILL → err_stray=1, batch_cnt stays 1.
- Reset mid-operation: assert rst_n after 2 words accepted, and again in WAIT → all outputs at reset values asynchronously. Next 4 words form a fresh batch starting at index 0.
- Wrap: CNT_W=2, run 4 full batches with sorter model → batch_cnt sequence 1,2,3,0. No err_stray.

Source files
------------

// File: rtl/sort_loader_if.sv
// Bus between the serial producer, the loader and the bubble sorter.
// The master side drives the word stream and the sorter's out_vld; the slave side is the loader.
interface sort_loader_if #(
  parameter int DATA_W = 4,
  parameter int DATA_N = 4,
  parameter int CNT_W  = 8
);
  logic              in_vld;
  logic [DATA_W-1:0] in_data;
  logic              in_rdy;
  logic [DATA_W-1:0] data_arr [DATA_N-1:0];
  logic              start_sort;
  logic              sort_out_vld;
  logic              busy;
  logic [CNT_W-1:0]  batch_cnt;
  logic              err_stray;

  modport master (
    output in_vld, in_data, sort_out_vld,
    input  in_rdy, data_arr, start_sort, busy, batch_cnt, err_stray
  );

  modport slave (
    input  in_vld, in_data, sort_out_vld,
    output in_rdy, data_arr, start_sort, busy, batch_cnt, err_stray
  );
endinterface

// File: rtl/sort_loader.sv
// Gathers DATA_N serial words into the sorter's parallel input, fires start_sort,
// then blocks input until the sorter has emitted DATA_N valid words.
module sort_loader #(
  parameter int DATA_W = 4,
  parameter int DATA_N = 4,
  parameter int CNT_W  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  sort_loader_if.slave bus
);

  localparam int IDX_W = ($clog2(DATA_N) < 1) ? 1 : $clog2(DATA_N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_N - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state_q,  state_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] arr_q [DATA_N-1:0];
  logic [DATA_W-1:0] arr_d [DATA_N-1:0];
  logic [CNT_W-1:0]  batch_cnt_q, batch_cnt_d;
  logic              err_q, err_d;
  logic              in_rdy_q, in_rdy_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_cnt_d    = rd_cnt_q;
    arr_d       = arr_q;
    batch_cnt_d = batch_cnt_q;
    // Sorter output outside WAIT means the two blocks disagree about batch ownership.
    err_d       = err_q | (bus.sort_out_vld && (state_q != WAIT));

    case (state_q)
      FILL: begin
        if (bus.in_vld) begin
          arr_d[wr_idx_q] = bus.in_data;
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d = '0;
            state_d  = START;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (bus.sort_out_vld) begin
          if (rd_cnt_q == LAST_IDX) begin
            rd_cnt_d    = '0;
            batch_cnt_d = batch_cnt_q + 1'b1;
            state_d     = FILL;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase

    // Handshake outputs follow the next state so they register alongside it.
    in_rdy_d = (state_d == FILL);
    start_d  = (state_d == START);
    busy_d   = (state_d != FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      wr_idx_q    <= '0;
      rd_cnt_q    <= '0;
      batch_cnt_q <= '0;
      err_q       <= 1'b0;
      in_rdy_q    <= 1'b1;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < DATA_N; i++) arr_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_cnt_q    <= rd_cnt_d;
      batch_cnt_q <= batch_cnt_d;
      err_q       <= err_d;
      in_rdy_q    <= in_rdy_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      for (int i = 0; i < DATA_N; i++) arr_q[i] <= arr_d[i];
    end
  end

  assign bus.in_rdy     = in_rdy_q;
  assign bus.start_sort = start_q;
  assign bus.busy       = busy_q;
  assign bus.batch_cnt  = batch_cnt_q;
  assign bus.err_stray  = err_q;
  assign bus.data_arr   = arr_q;

endmodule

// File: tb/tb_sort_loader.sv
// Directed bench for sort_loader: reset, gapped fill, input blocking, completion,
// stray pulses, asynchronous reset mid-batch and batch counter wrap (CNT_W=2).
module tb_sort_loader;

  localparam int DATA_W = 4;
  localparam int DATA_N = 4;
  localparam int CNT_W  = 2;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   starts;

  sort_loader_if #(.DATA_W(DATA_W), .DATA_N(DATA_N), .CNT_W(CNT_W)) bus ();

  sort_loader #(.DATA_W(DATA_W), .DATA_N(DATA_N), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] arr_packed();
    logic [15:0] p;
    for (int i = 0; i < DATA_N; i++) p[i*4 +: 4] = bus.data_arr[i];
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] v);
    bus.in_vld  = 1'b1;
    bus.in_data = v;
    tick();
    bus.in_vld  = 1'b0;
  endtask

  task automatic pulse_out();
    bus.sort_out_vld = 1'b1;
    tick();
    bus.sort_out_vld = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".in_rdy"},     bus.in_rdy, 1);
    chk({tag, ".start_sort"}, bus.start_sort, 0);
    chk({tag, ".busy"},       bus.busy, 0);
    chk({tag, ".batch_cnt"},  bus.batch_cnt, 0);
    chk({tag, ".err_stray"},  bus.err_stray, 0);
    chk({tag, ".data_arr"},   arr_packed(), 0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    bus.in_vld = 1'b0;
    bus.in_data = '0;
    bus.sort_out_vld = 1'b0;

    // Reset then idle
    rst_n = 1'b0;
    repeat (3) tick();
    chk_reset_vals("rst_hold");
    rst_n = 1'b1;
    tick();
    chk_reset_vals("rst_idle");

    // Fill with gaps: 3, 9, 1, 12
    send(4'd3);  chk("fill0.in_rdy", bus.in_rdy, 1); tick();
    send(4'd9);  chk("fill1.start", bus.start_sort, 0); tick();
    send(4'd1);  chk("fill2.busy", bus.busy, 0); tick();
    send(4'd12);
    chk("fill3.start", bus.start_sort, 1);
    chk("fill3.in_rdy", bus.in_rdy, 0);
    chk("fill3.busy", bus.busy, 1);
    chk("fill3.arr", arr_packed(), 16'hC193);
    tick();
    chk("wait.start_off", bus.start_sort, 0);
    chk("wait.busy", bus.busy, 1);

    // Blocking in WAIT
    starts = 0;
    bus.in_vld = 1'b1;
    bus.in_data = 4'd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.start_sort || bus.in_rdy) starts++;
    end
    bus.in_vld = 1'b0;
    chk("block.starts_or_rdy", starts, 0);
    chk("block.arr", arr_packed(), 16'hC193);

    // Completion with non-consecutive pulses
    for (int i = 0; i < 3; i++) begin
      pulse_out();
      tick();
    end
    chk("done3.busy", bus.busy, 1);
    chk("done3.batch", bus.batch_cnt, 0);
    pulse_out();
    chk("done4.batch", bus.batch_cnt, 1);
    chk("done4.in_rdy", bus.in_rdy, 1);
    chk("done4.busy", bus.busy, 0);
    chk("done4.err", bus.err_stray, 0);
    tick();
    pulse_out();
    chk("stray_fill.err", bus.err_stray, 1);
    chk("stray_fill.batch", bus.batch_cnt, 1);
    chk("stray_fill.in_rdy", bus.in_rdy, 1);

    // Asynchronous reset after two words
    send(4'd5);
    send(4'd6);
    chk("part.arr", arr_packed(), 16'hC165);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("rst_mid");
    rst_n = 1'b1;
    tick();
    send(4'hA); send(4'hB); send(4'hC); send(4'hD);
    chk("fresh.arr", arr_packed(), 16'hDCBA);
    chk("fresh.start", bus.start_sort, 1);
    tick();
    chk("fresh.wait_busy", bus.busy, 1);

    // Asynchronous reset in WAIT
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("rst_wait");
    rst_n = 1'b1;
    tick();

    // Stray pulse in the START cycle is flagged and not counted
    send(4'd1); send(4'd2); send(4'd3); send(4'd4);
    chk("st.start", bus.start_sort, 1);
    pulse_out();
    chk("st.err", bus.err_stray, 1);
    for (int i = 0; i < 3; i++) pulse_out();
    chk("st.not_counted_busy", bus.busy, 1);
    pulse_out();
    chk("st.done_batch", bus.batch_cnt, 1);
    chk("st.done_rdy", bus.in_rdy, 1);

    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk("wrap.pre_batch", bus.batch_cnt, 0);

    // Wrap: four batches with a back-to-back sorter model
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < DATA_N; w++) send(4'((b * 4 + w) & 15));
      chk($sformatf("wrap%0d.start", b), bus.start_sort, 1);
      tick();
      for (int w = 0; w < DATA_N; w++) pulse_out();
      chk($sformatf("wrap%0d.batch", b), bus.batch_cnt, 32'((b + 1) % 4));
      chk($sformatf("wrap%0d.in_rdy", b), bus.in_rdy, 1);
      chk($sformatf("wrap%0d.err", b), bus.err_stray, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
